div_pipe: RTL

//  Fixed-latency pipelined signed integer/fixed-point divider core.

---
 rtl/div_pipe_if.sv | 23 ++
 rtl/div_pipe.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/div_pipe_if.sv
// Operand/result bundle for the pipelined divider core.
// The producer owns in_valid/numer/denom and the divider owns the results.
interface div_pipe_if #(
  parameter int DATA_WIDTH = 32
);
  logic                         in_valid;
  logic signed [DATA_WIDTH-1:0] numer;
  logic signed [DATA_WIDTH-1:0] denom;
  logic                         out_valid;
  logic signed [DATA_WIDTH-1:0] quotient;
  logic signed [DATA_WIDTH-1:0] remain;
  logic                         out_overflow;

  modport master (
    output in_valid, numer, denom,
    input  out_valid, quotient, remain, out_overflow
  );

  modport slave (
    input  in_valid, numer, denom,
    output out_valid, quotient, remain, out_overflow
  );
endinterface

// File: rtl/div_pipe.sv
// Fixed-latency pipelined signed restoring divider: quotient = (numer<<S)/denom, truncating.
// Optional quotient clamping with overflow flag when DIV_SATURATE_EN is defined.
module div_pipe #(
  parameter int DATA_WIDTH           = 32,
  parameter int PIPELINE             = 4,
  parameter int SCALING_FACTOR_POWER = 0
) (
  input logic       clk,
  input logic       rst,
  div_pipe_if.slave bus
);
  localparam int W    = DATA_WIDTH;
  localparam int N    = DATA_WIDTH + SCALING_FACTOR_POWER;
  localparam int RW   = DATA_WIDTH + 1;
  localparam int N1   = N + 1;
  localparam int LAST = PIPELINE - 1;
  localparam int ITER = (N + LAST - 1) / LAST;

  // Index k of each array holds the state leaving pipeline stage k.
  logic          vld_q  [LAST];
  logic [RW-1:0] rem_q  [LAST];
  logic [N-1:0]  num_q  [LAST];
  logic [RW-1:0] d_q    [LAST];
  logic          sq_q   [LAST];
  logic          sr_q   [LAST];
  logic          dz_q   [LAST];
  logic [W-1:0]  nraw_q [LAST];

  logic [RW+N-1:0] step_d [LAST];
  logic [W-1:0]    nabs_d, dabs_d;
  logic [N-1:0]    num0_d;
  logic [W-1:0]    quot_d, rem_o_d;
  logic            vld_o_q;
  logic [W-1:0]    quot_q, rem_o_q;

  // Quotient bits shift into the vacated LSBs of the numerator register.
  function automatic logic [RW+N-1:0] div_steps(input logic [RW-1:0] rem,
                                                input logic [N-1:0]  num,
                                                input logic [RW-1:0] d,
                                                input int            start);
    for (int i = 0; i < ITER; i++) begin
      if (start + i < N) begin
        rem = {rem[RW-2:0], num[N-1]};
        num = {num[N-2:0], 1'b0};
        if (rem >= d) begin
          rem    = rem - d;
          num[0] = 1'b1;
        end
      end
    end
    return {rem, num};
  endfunction

`ifdef DIV_SATURATE_EN
  function automatic logic quot_ovf(input logic [N-1:0] qmag, input logic neg);
    logic [N1-1:0] lim;
    lim = (N1'(1) << (W - 1)) - (neg ? N1'(0) : N1'(1));
    return {1'b0, qmag} > lim;
  endfunction
`endif

  function automatic logic [W-1:0] quot_result(input logic [N-1:0] qmag, input logic neg);
    logic [N-1:0] qs;
    qs = neg ? -qmag : qmag;
`ifdef DIV_SATURATE_EN
    if (quot_ovf(qmag, neg)) return neg ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
    return qs[W-1:0];
  endfunction

  function automatic logic [W-1:0] rem_result(input logic [RW-1:0] rmag, input logic neg);
    logic [RW-1:0] rs;
    rs = neg ? -rmag : rmag;
    return rs[W-1:0];
  endfunction

  always_comb begin
    nabs_d = bus.numer[W-1] ? -bus.numer : bus.numer;
    dabs_d = bus.denom[W-1] ? -bus.denom : bus.denom;
    num0_d = N'(nabs_d) << SCALING_FACTOR_POWER;
    for (int k = 0; k < LAST; k++) begin
      step_d[k] = div_steps(rem_q[k], num_q[k], d_q[k], k * ITER);
    end
  end

  always_comb begin
    quot_d  = quot_result(step_d[LAST-1][N-1:0], sq_q[LAST-1]);
    rem_o_d = rem_result(step_d[LAST-1][RW+N-1:N], sr_q[LAST-1]);
    if (dz_q[LAST-1]) begin
      quot_d  = '0;
      rem_o_d = nraw_q[LAST-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < LAST; k++) begin
        vld_q[k]  <= 1'b0;
        rem_q[k]  <= '0;
        num_q[k]  <= '0;
        d_q[k]    <= '0;
        sq_q[k]   <= 1'b0;
        sr_q[k]   <= 1'b0;
        dz_q[k]   <= 1'b0;
        nraw_q[k] <= '0;
      end
      vld_o_q <= 1'b0;
      quot_q  <= '0;
      rem_o_q <= '0;
    end else begin
      // stage 0: magnitudes and signs
      vld_q[0]  <= bus.in_valid;
      rem_q[0]  <= '0;
      num_q[0]  <= num0_d;
      d_q[0]    <= {1'b0, dabs_d};
      sq_q[0]   <= bus.numer[W-1] ^ bus.denom[W-1];
      sr_q[0]   <= bus.numer[W-1];
      dz_q[0]   <= (bus.denom == '0);
      nraw_q[0] <= bus.numer;
      // stages 1..PIPELINE-2: restoring iterations
      for (int k = 1; k < LAST; k++) begin
        vld_q[k]  <= vld_q[k-1];
        rem_q[k]  <= step_d[k-1][RW+N-1:N];
        num_q[k]  <= step_d[k-1][N-1:0];
        d_q[k]    <= d_q[k-1];
        sq_q[k]   <= sq_q[k-1];
        sr_q[k]   <= sr_q[k-1];
        dz_q[k]   <= dz_q[k-1];
        nraw_q[k] <= nraw_q[k-1];
      end
      // final stage: last iterations, sign application, output registers
      vld_o_q <= vld_q[LAST-1];
      quot_q  <= quot_d;
      rem_o_q <= rem_o_d;
    end
  end

`ifdef DIV_SATURATE_EN
  logic ovf_q;
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= quot_ovf(step_d[LAST-1][N-1:0], sq_q[LAST-1]) && !dz_q[LAST-1];
  end
  assign bus.out_overflow = ovf_q;
`else
  assign bus.out_overflow = 1'b0;
`endif

  assign bus.out_valid = vld_o_q;
  assign bus.quotient  = quot_q;
  assign bus.remain    = rem_o_q;
endmodule
